// File: rtl/galaga_pkg.sv
// Shared types, palette and colour lookup for the Galaga sprite compositor.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package galaga_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int PIXEL_BITS   = 4;
  localparam int PALETTE_SIZE = 12;

  localparam logic [23:0] PALETTE [PALETTE_SIZE] = '{
    24'h000000, 24'hDEDEDE, 24'hEC3223, 24'hCE5223,
    24'hFFFD54, 24'h74FBDF, 24'h419596, 24'h276AD6,
    24'hB8B9DB, 24'h001DD5, 24'h8929D6, 24'hEA3CD7
  };

  // Nibbles past the end of the palette are drawn black (but still opaque).
  function automatic rgb_t palette_rgb(input logic [PIXEL_BITS-1:0] nib);
    logic [23:0] c;
    c = 24'h000000;
    if (nib < PIXEL_BITS'(PALETTE_SIZE)) c = PALETTE[nib];
    return rgb_t'(c);
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Bundles the pixel stream, sprite attributes, sprite-ROM port and colour output.
// Latency: none (wiring only).
// Backpressure: none; the pixel stream is free-running at the pixel clock.
interface sprite_compositor_if #(
  parameter int SPRITE_COUNT = 8,
  parameter int TILE_BITS    = 6,
  parameter int SPRITE_W     = 16
);
  import galaga_pkg::*;

  logic                                   pix_valid_i;
  logic                                   frame_start_i;
  coord_t                                 draw_xpos_i;
  coord_t                                 draw_ypos_i;
  logic   [SPRITE_COUNT-1:0]              sprite_en_i;
  logic   [SPRITE_COUNT-1:0]              sprite_flip_i;
  coord_t [SPRITE_COUNT-1:0]              sprite_xpos_i;
  coord_t [SPRITE_COUNT-1:0]              sprite_ypos_i;
  logic   [SPRITE_COUNT-1:0][TILE_BITS-1:0]  sprite_tile_i;
  logic   [SPRITE_COUNT-1:0][TILE_BITS+3:0]  rom_addr_o;
  logic   [SPRITE_COUNT-1:0][4*SPRITE_W-1:0] rom_data_i;
  logic   [7:0]                           red_o;
  logic   [7:0]                           green_o;
  logic   [7:0]                           blue_o;
  logic                                   pix_valid_o;
  logic   [SPRITE_COUNT-1:0]              collision_o;

  modport slave (
    input  pix_valid_i, frame_start_i, draw_xpos_i, draw_ypos_i,
    input  sprite_en_i, sprite_flip_i, sprite_xpos_i, sprite_ypos_i, sprite_tile_i,
    input  rom_data_i,
    output rom_addr_o, red_o, green_o, blue_o, pix_valid_o, collision_o
  );

  modport master (
    output pix_valid_i, frame_start_i, draw_xpos_i, draw_ypos_i,
    output sprite_en_i, sprite_flip_i, sprite_xpos_i, sprite_ypos_i, sprite_tile_i,
    output rom_data_i,
    input  rom_addr_o, red_o, green_o, blue_o, pix_valid_o, collision_o
  );

endinterface

// File: rtl/sprite_prio_enc.sv
// Fixed-priority encoder (index 0 wins) with any-hit and multi-hit flags.
// Latency: combinational.
// Backpressure: not applicable.
module sprite_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
    any_o   = |req_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_o = |(req_i & (req_i - N'(1)));
  end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite-over-playfield compositor with sticky per-frame collision flags.
// Latency: exactly 3 pixel clocks from draw coordinates to colour output.
// Backpressure: none; every pixel clock advances the pipeline, invalid pixels flow as bubbles.
module sprite_compositor
  import galaga_pkg::*;
#(
  parameter int SPRITE_COUNT = 8,
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int TILE_BITS    = 6,
  parameter int BORDER_L_X   = 131,
  parameter int BORDER_R_X   = 506,
  parameter int BORDER_W     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sprite_compositor_if.slave bus
);

  localparam int COL_BITS  = $clog2(SPRITE_W);
  localparam int ADDR_BITS = TILE_BITS + 4;
  localparam int ROW_BITS  = 4 * SPRITE_W;
  localparam int IDX_W     = (SPRITE_COUNT > 1) ? $clog2(SPRITE_COUNT) : 1;

  // S0 state
  logic [SPRITE_COUNT-1:0]                hit_s0_d, hit_s0_q;
  logic [SPRITE_COUNT-1:0][COL_BITS-1:0]  col_s0_d, col_s0_q;
  logic [SPRITE_COUNT-1:0][ADDR_BITS-1:0] rom_addr_d, rom_addr_q;
  coord_t                                 x_s0_d, x_s0_q, y_s0_d, y_s0_q;
  logic                                   vld_s0_d, vld_s0_q;

  // S1 state
  logic [SPRITE_COUNT-1:0]                hit_s1_d, hit_s1_q;
  logic [SPRITE_COUNT-1:0][COL_BITS-1:0]  col_s1_d, col_s1_q;
  logic [SPRITE_COUNT-1:0][ROW_BITS-1:0]  rom_data_s1_d, rom_data_s1_q;
  coord_t                                 x_s1_d, x_s1_q, y_s1_d, y_s1_q;
  logic                                   vld_s1_d, vld_s1_q;

  // S2 state
  rgb_t                                   rgb_d, rgb_q;
  logic                                   pix_vld_d, pix_vld_q;
  logic [SPRITE_COUNT-1:0]                collision_d, collision_q;

  // S2 combinational
  logic [SPRITE_COUNT-1:0][PIXEL_BITS-1:0] nib;
  logic [SPRITE_COUNT-1:0]                 opaque;
  logic [IDX_W-1:0]                        win_idx;
  logic                                    any_opaque;
  logic                                    multi_hit;
  logic                                    in_border;

  for (genvar i = 0; i < SPRITE_COUNT; i++) begin : g_slot
    logic [10:0]          dx;
    logic [10:0]          dy;
    logic                 hit;
    logic [COL_BITS-1:0]  col;
    logic [ADDR_BITS-1:0] addr;

    // Bounding-box test at 11 bits so a sprite hanging off the right edge never wraps to x=0.
    always_comb begin
      dx   = {1'b0, bus.draw_xpos_i} - {1'b0, bus.sprite_xpos_i[i]};
      dy   = {1'b0, bus.draw_ypos_i} - {1'b0, bus.sprite_ypos_i[i]};
      hit  = bus.sprite_en_i[i] && (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));
      col  = dx[COL_BITS-1:0];
      if (bus.sprite_flip_i[i]) col = COL_BITS'(SPRITE_W - 1) - col;
      addr = '0;
      if (hit) addr = ADDR_BITS'(bus.sprite_tile_i[i]) * ADDR_BITS'(SPRITE_H) + ADDR_BITS'(dy);
    end

    assign hit_s0_d[i]   = hit;
    assign col_s0_d[i]   = col;
    assign rom_addr_d[i] = addr;
  end

  // Coordinates and valid ride along with the hits; S1 captures the ROM row beside them.
  always_comb begin
    x_s0_d        = bus.draw_xpos_i;
    y_s0_d        = bus.draw_ypos_i;
    vld_s0_d      = bus.pix_valid_i;
    hit_s1_d      = hit_s0_q;
    col_s1_d      = col_s0_q;
    x_s1_d        = x_s0_q;
    y_s1_d        = y_s0_q;
    vld_s1_d      = vld_s0_q;
    rom_data_s1_d = bus.rom_data_i;
  end

  // Pick each slot's nibble; leftmost pixel lives in the most significant nibble.
  always_comb begin
    nib    = '0;
    opaque = '0;
    for (int i = 0; i < SPRITE_COUNT; i++) begin
      logic [ROW_BITS-1:0] row;
      row       = rom_data_s1_q[i] << {col_s1_q[i], 2'b00};
      nib[i]    = row[ROW_BITS-1 -: PIXEL_BITS];
      opaque[i] = hit_s1_q[i] && (nib[i] != '0);
    end
  end

  sprite_prio_enc #(
    .N     (SPRITE_COUNT),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i   (opaque),
    .idx_o   (win_idx),
    .any_o   (any_opaque),
    .multi_o (multi_hit)
  );

  // Final colour, output gating and collision accumulation.
  always_comb begin
    in_border = (y_s1_q < coord_t'(480)) &&
                (((x_s1_q >= coord_t'(BORDER_L_X)) && (x_s1_q < coord_t'(BORDER_L_X + BORDER_W))) ||
                 ((x_s1_q >= coord_t'(BORDER_R_X)) && (x_s1_q < coord_t'(BORDER_R_X + BORDER_W))));
    rgb_d     = '0;
    if (vld_s1_q) begin
      if (any_opaque)     rgb_d = palette_rgb(nib[win_idx]);
      else if (in_border) rgb_d = rgb_t'(24'hFFFFFF);
    end
    pix_vld_d = vld_s1_q;
    // Frame start clears first so a collision on the same edge still lands.
    collision_d = bus.frame_start_i ? '0 : collision_q;
    if (vld_s1_q && multi_hit) collision_d = collision_d | opaque;
  end

  // Pipeline registers; reset flushes every stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_s0_q      <= '0;
      col_s0_q      <= '0;
      rom_addr_q    <= '0;
      x_s0_q        <= '0;
      y_s0_q        <= '0;
      vld_s0_q      <= 1'b0;
      hit_s1_q      <= '0;
      col_s1_q      <= '0;
      rom_data_s1_q <= '0;
      x_s1_q        <= '0;
      y_s1_q        <= '0;
      vld_s1_q      <= 1'b0;
      rgb_q         <= '0;
      pix_vld_q     <= 1'b0;
      collision_q   <= '0;
    end else begin
      hit_s0_q      <= hit_s0_d;
      col_s0_q      <= col_s0_d;
      rom_addr_q    <= rom_addr_d;
      x_s0_q        <= x_s0_d;
      y_s0_q        <= y_s0_d;
      vld_s0_q      <= vld_s0_d;
      hit_s1_q      <= hit_s1_d;
      col_s1_q      <= col_s1_d;
      rom_data_s1_q <= rom_data_s1_d;
      x_s1_q        <= x_s1_d;
      y_s1_q        <= y_s1_d;
      vld_s1_q      <= vld_s1_d;
      rgb_q         <= rgb_d;
      pix_vld_q     <= pix_vld_d;
      collision_q   <= collision_d;
    end
  end

  assign bus.rom_addr_o  = rom_addr_q;
  assign bus.red_o       = rgb_q.r;
  assign bus.green_o     = rgb_q.g;
  assign bus.blue_o      = rgb_q.b;
  assign bus.pix_valid_o = pix_vld_q;
  assign bus.collision_o = collision_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a combinational model of the sprite ROMs.
// Latency: checks outputs exactly 3 clocks after each driven pixel.
// Backpressure: none to model; inputs change on the falling edge.
module tb_sprite_compositor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] rom_mem [1024];

  sprite_compositor_if #(.SPRITE_COUNT(8), .TILE_BITS(6), .SPRITE_W(16)) bus ();

  sprite_compositor #(
    .SPRITE_COUNT(8), .SPRITE_W(16), .SPRITE_H(16), .TILE_BITS(6),
    .BORDER_L_X(131), .BORDER_R_X(506), .BORDER_W(2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_rom
    assign bus.rom_data_i[g] = rom_mem[bus.rom_addr_o[g]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int x, input int y, input logic v);
    bus.draw_xpos_i = 10'(x);
    bus.draw_ypos_i = 10'(y);
    bus.pix_valid_i = v;
  endtask

  task automatic set_sprite(input int s, input logic en, input logic flip,
                            input int x, input int y, input int tile);
    bus.sprite_en_i[s]   = en;
    bus.sprite_flip_i[s] = flip;
    bus.sprite_xpos_i[s] = 10'(x);
    bus.sprite_ypos_i[s] = 10'(y);
    bus.sprite_tile_i[s] = 6'(tile);
  endtask

  task automatic clear_sprites();
    for (int s = 0; s < 8; s++) set_sprite(s, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic set_nib(input int addr, input int col, input logic [3:0] v);
    rom_mem[addr][63-4*col -: 4] = v;
  endtask

  task automatic frame_clear();
    drive(0, 300, 1'b0);
    bus.frame_start_i = 1'b1;
    cyc(1);
    bus.frame_start_i = 1'b0;
  endtask

  // Drive one valid pixel, then bubbles, and sample the output 3 clocks later.
  task automatic pixel_out(input int x, input int y, output logic [23:0] rgb, output logic pv);
    drive(x, y, 1'b1);
    cyc(1);
    drive(0, 300, 1'b0);
    cyc(2);
    rgb = {bus.red_o, bus.green_o, bus.blue_o};
    pv  = bus.pix_valid_o;
  endtask

  task automatic test_reset();
    logic [23:0] rgb;
    clear_sprites();
    set_sprite(1, 1'b1, 1'b0, 300, 200, 1);
    set_sprite(3, 1'b1, 1'b0, 300, 200, 2);
    drive(305, 204, 1'b1);
    cyc(4);
    rst = 1'b1;
    cyc(2);
    checks++;
    if (bus.rom_addr_o !== '0) begin
      errors++; $display("FAIL reset_rom_addr: got %h expected 0", bus.rom_addr_o);
    end
    drive(0, 300, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      rgb = {bus.red_o, bus.green_o, bus.blue_o};
      checks++;
      if (rgb !== 24'h0 || bus.pix_valid_o !== 1'b0 || bus.collision_o !== 8'h00) begin
        errors++;
        $display("FAIL reset_out%0d: got rgb=%h pv=%b coll=%b expected rgb=000000 pv=0 coll=00000000",
                 k, rgb, bus.pix_valid_o, bus.collision_o);
      end
    end
  endtask

  task automatic test_single();
    logic [23:0] rgb;
    clear_sprites();
    set_sprite(0, 1'b1, 1'b0, 200, 100, 5);
    drive(203, 107, 1'b1);
    cyc(1);
    checks++;
    if (bus.rom_addr_o[0] !== 10'd87) begin
      errors++; $display("FAIL single_rom_addr: got %0d expected 87", bus.rom_addr_o[0]);
    end
    drive(0, 300, 1'b0);
    cyc(1);
    checks++;
    if (bus.pix_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_early: got pv=%b expected 0 at 2 cycles", bus.pix_valid_o);
    end
    cyc(1);
    rgb = {bus.red_o, bus.green_o, bus.blue_o};
    checks++;
    if (rgb !== 24'hFFFD54 || bus.pix_valid_o !== 1'b1) begin
      errors++; $display("FAIL single_rgb: got rgb=%h pv=%b expected FFFD54 pv=1", rgb, bus.pix_valid_o);
    end
  endtask

  task automatic test_flip();
    logic [23:0] rgb;
    logic pv;
    set_sprite(0, 1'b1, 1'b1, 200, 100, 5);
    pixel_out(212, 107, rgb, pv);
    checks++;
    if (rgb !== 24'hFFFD54 || pv !== 1'b1) begin
      errors++; $display("FAIL flip_rgb: got rgb=%h pv=%b expected FFFD54 pv=1", rgb, pv);
    end
    set_sprite(0, 1'b1, 1'b0, 200, 100, 5);
    pixel_out(212, 107, rgb, pv);
    checks++;
    if (rgb !== 24'h000000 || pv !== 1'b1) begin
      errors++; $display("FAIL noflip_rgb: got rgb=%h pv=%b expected 000000 pv=1", rgb, pv);
    end
  endtask

  task automatic test_border();
    logic [23:0] rgb;
    logic pv;
    int   px [5] = '{132, 132, 131, 132, 140};
    int   py [5] = '{50,  50,  50,  51,  50};
    logic [23:0] exp [5] = '{24'hFFFFFF, 24'h001DD5, 24'hFFFFFF, 24'h000000, 24'h000000};
    clear_sprites();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) set_sprite(0, 1'b1, 1'b0, 128, 40, 3);
      pixel_out(px[k], py[k], rgb, pv);
      checks++;
      if (rgb !== exp[k] || pv !== 1'b1) begin
        errors++; $display("FAIL border%0d (%0d,%0d): got rgb=%h pv=%b expected %h pv=1",
                           k, px[k], py[k], rgb, pv, exp[k]);
      end
    end
    clear_sprites();
    pixel_out(132, 480, rgb, pv);
    checks++;
    if (rgb !== 24'h000000) begin
      errors++; $display("FAIL border_y480: got rgb=%h expected 000000", rgb);
    end
  endtask

  task automatic test_priority();
    logic [23:0] rgb;
    logic pv;
    clear_sprites();
    frame_clear();
    set_sprite(1, 1'b1, 1'b0, 300, 200, 1);
    set_sprite(3, 1'b1, 1'b0, 300, 200, 2);
    pixel_out(305, 204, rgb, pv);
    checks++;
    if (rgb !== 24'hEC3223) begin
      errors++; $display("FAIL prio_rgb: got %h expected EC3223", rgb);
    end
    checks++;
    if (bus.collision_o !== 8'b0000_1010) begin
      errors++; $display("FAIL prio_coll: got %b expected 00001010", bus.collision_o);
    end
    pixel_out(0, 300, rgb, pv);
    checks++;
    if (bus.collision_o !== 8'b0000_1010) begin
      errors++; $display("FAIL coll_hold: got %b expected 00001010", bus.collision_o);
    end
    set_sprite(1, 1'b0, 1'b0, 300, 200, 1);
    pixel_out(305, 204, rgb, pv);
    checks++;
    if (rgb !== 24'h276AD6 || bus.collision_o !== 8'b0000_1010) begin
      errors++; $display("FAIL slot3_only: got rgb=%h coll=%b expected 276AD6 coll=00001010",
                         rgb, bus.collision_o);
    end
    frame_clear();
    checks++;
    if (bus.collision_o !== 8'h00) begin
      errors++; $display("FAIL frame_clear: got %b expected 00000000", bus.collision_o);
    end
    // Re-arm with slots 1,3 then collide slots 1,2 on the frame_start edge.
    set_sprite(1, 1'b1, 1'b0, 300, 200, 1);
    pixel_out(305, 204, rgb, pv);
    set_sprite(3, 1'b0, 1'b0, 300, 200, 2);
    set_sprite(2, 1'b1, 1'b0, 300, 200, 2);
    drive(305, 204, 1'b1);
    cyc(1);
    drive(0, 300, 1'b0);
    cyc(1);
    bus.frame_start_i = 1'b1;
    cyc(1);
    bus.frame_start_i = 1'b0;
    checks++;
    if (bus.collision_o !== 8'b0000_0110) begin
      errors++; $display("FAIL coll_same_edge: got %b expected 00000110", bus.collision_o);
    end
  endtask

  task automatic test_edge_bubble();
    logic [23:0] rgb;
    logic pv;
    clear_sprites();
    frame_clear();
    set_sprite(0, 1'b1, 1'b0, 1015, 0, 0);
    for (int x = 0; x < 7; x++) begin
      pixel_out(x, 0, rgb, pv);
      checks++;
      if (rgb !== 24'h000000 || pv !== 1'b1) begin
        errors++; $display("FAIL edge_x%0d: got rgb=%h pv=%b expected 000000 pv=1", x, rgb, pv);
      end
    end
    pixel_out(1020, 0, rgb, pv);
    checks++;
    if (rgb !== 24'hDEDEDE) begin
      errors++; $display("FAIL edge_x1020: got %h expected DEDEDE", rgb);
    end
    clear_sprites();
    set_sprite(1, 1'b1, 1'b0, 300, 200, 1);
    set_sprite(3, 1'b1, 1'b0, 300, 200, 2);
    drive(305, 204, 1'b0);
    cyc(3);
    rgb = {bus.red_o, bus.green_o, bus.blue_o};
    checks++;
    if (bus.collision_o !== 8'h00 || bus.pix_valid_o !== 1'b0 || rgb !== 24'h0) begin
      errors++; $display("FAIL bubble: got coll=%b pv=%b rgb=%h expected 00000000 0 000000",
                         bus.collision_o, bus.pix_valid_o, rgb);
    end
    set_sprite(1, 1'b0, 1'b0, 300, 200, 1);
    drive(305, 204, 1'b1);
    cyc(1);
    checks++;
    if (bus.rom_addr_o[1] !== 10'd0 || bus.rom_addr_o[3] !== 10'd36) begin
      errors++; $display("FAIL disabled_addr: got a1=%0d a3=%0d expected 0 36",
                         bus.rom_addr_o[1], bus.rom_addr_o[3]);
    end
    drive(0, 300, 1'b0);
    cyc(2);
    rgb = {bus.red_o, bus.green_o, bus.blue_o};
    checks++;
    if (rgb !== 24'h276AD6 || bus.collision_o !== 8'h00) begin
      errors++; $display("FAIL disabled_slot: got rgb=%h coll=%b expected 276AD6 00000000",
                         rgb, bus.collision_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] rgb;
    logic [23:0] exp [3] = '{24'hFFFD54, 24'hFFFFFF, 24'h000000};
    clear_sprites();
    set_sprite(0, 1'b1, 1'b0, 200, 100, 5);
    drive(203, 107, 1'b1);
    cyc(1);
    set_sprite(0, 1'b1, 1'b1, 600, 300, 9);
    drive(132, 50, 1'b1);
    cyc(1);
    drive(10, 10, 1'b1);
    cyc(1);
    drive(0, 300, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rgb = {bus.red_o, bus.green_o, bus.blue_o};
      checks++;
      if (rgb !== exp[k] || bus.pix_valid_o !== 1'b1) begin
        errors++; $display("FAIL b2b%0d: got rgb=%h pv=%b expected %h pv=1",
                           k, rgb, bus.pix_valid_o, exp[k]);
      end
      cyc(1);
    end
    checks++;
    if (bus.pix_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_tail: got pv=%b expected 0", bus.pix_valid_o);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom_mem[a] = 64'h0;
    rom_mem[0] = 64'h1111_1111_1111_1111;
    set_nib(87, 3, 4'd4);
    set_nib(20, 5, 4'd2);
    set_nib(36, 5, 4'd7);
    set_nib(58, 4, 4'd9);
    set_nib(59, 4, 4'd13);
    bus.frame_start_i = 1'b0;
    drive(0, 300, 1'b0);
    clear_sprites();
    cyc(2);
    rst = 1'b0;
    cyc(1);
    test_reset();
    test_single();
    test_flip();
    test_border();
    test_priority();
    test_edge_bubble();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
